abs_diff_delta_decoder: RTL and testbench
=========================================

// Module: abs_diff_delta_decoder
// PURPOSE
//  Receive-side counterpart of the abs_diff encoder path: rebuilds a sample stream from
//  (sign, |a-b|) delta tokens. Each frame starts with a keyframe token carrying an absolute value;
//  later tokens add or subtract a magnitude. Sits between the token FIFO and the sample sink.
//  Uses valid/ready on both sides.
// PARAMETERS
//  DW        8   reconstructed sample width (bits)
//  MW        8   delta magnitude width; MW<=DW
//  FRAME_LEN 16  samples per frame, keyframe included; >=2
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  in_valid     in   1   token valid
//  in_ready     out  1   token accepted when in_valid&in_ready
//  in_key       in   1   1 = keyframe token: in_mag is the absolute sample value
//  in_sign      in   1   delta token: 0 = add in_mag, 1 = subtract in_mag; ignored on key
//  in_mag       in   MW  magnitude or keyframe value, zero-extended to DW
//  out_valid    out  1   sample valid
//  out_ready    in   1   sample consumed when out_valid&out_ready
//  out_data     out  DW  reconstructed sample
//  out_last     out  1   marks sample FRAME_LEN-1 of the frame
//  err_ovf      out  1   sticky: saturation (or wrap) occurred; cleared only by rst
//  err_nokey    out  1   sticky: delta token arrived while in WAIT_KEY; cleared only by rst
// BEHAVIOUR
//  Reset values: all outputs 0, in_ready 1, acc 0, cnt 0, state WAIT_KEY.
//  Output stage is one register.
//   - in_ready = ~out_valid | out_ready.
//   - Latency from an accepted token to out_valid is 1 cycle.
//   - While out_valid&~out_ready, out_data and out_last hold stable.
//   - Full throughput of 1 token/cycle under continuous out_ready.
//  FSM states: WAIT_KEY, RUN.
//   WAIT_KEY, key token   : acc=in_mag; emit acc; cnt=1; go to RUN.
//   WAIT_KEY, delta token : consume and drop, no output; set err_nokey.
//   RUN, delta token      : acc=step(acc,sign,mag); emit acc; cnt++.
//   RUN, key token        : restart the frame: acc=in_mag; emit; cnt=1; out_last=0.
//   Frame end             : the token making cnt==FRAME_LEN emits with out_last=1, then cnt=0
//                           and state goes to WAIT_KEY. The transition happens on acceptance,
//                           not on the output handshake.
//  Arithmetic (default): computed at DW+1 bits.
//   - Add results >2^DW-1 saturate to 2^DW-1.
//   - Subtract results <0 saturate to 0.
//   - Either case sets err_ovf.
//  A simultaneous output handshake and new token in the same cycle is a normal pass-through.
//  rst asserted mid-frame: any pending out_valid is lost, and the state returns to WAIT_KEY
//  immediately (asynchronous).
// CONFIGURATION
//  ABS_DIFF_DEC_WRAP_EN defined:
//   - Arithmetic is modulo 2^DW instead of saturating.
//   - err_ovf still sets on wrap.
//  ABS_DIFF_DEC_WRAP_EN undefined: saturating arithmetic as in BEHAVIOUR.
// STRUCTURE
//  abs_diff_pkg (shared package) holds:
//   - dec_state_e {WAIT_KEY, RUN}
//   - default DW/MW localparams
//   - sat_step() function, returning {ovf, result}
//  Sub-module abs_diff_acc_step: combinational acc +/- mag.
//   - Outputs result and ovf.
//   - Honours ABS_DIFF_DEC_WRAP_EN.
//   - Reused by the encoder-side checker.
//  The top level holds the FSM, cnt, acc, the output register and the sticky flags.
// TESTING
//  Key 100, then +5, -20 -> out 100, 105, 85; last=0; latency 1 cycle each.
//  Key 250, +10 -> out 255 and err_ovf=1. Key 3, -9 -> out 0.
//  With ABS_DIFF_DEC_WRAP_EN: key 250, +10 -> out 4 and err_ovf=1.
//  FRAME_LEN=4: key 10, +1, +1, +1 -> out 10, 11, 12, 13 with last only on 13; a following
//   delta +1 is dropped, err_nokey=1, and no output appears.
//  Hold out_ready=0 for 5 cycles after the first output:
//   - in_ready=0 and out_data stable.
//   - Release, then stream 8 tokens back-to-back -> 8 outputs in 8 cycles.
//  Key 50, +1, then rst pulse mid-stream -> outputs 0, state WAIT_KEY; the next key 7 -> out 7.

Source files
------------

// File: rtl/abs_diff_pkg.sv
// -----------------------------------------------------------------------------
// abs_diff_pkg
// Purpose : Shared definitions for the abs_diff delta codec path. It holds the
//           decoder state type, the default widths and a saturating step
//           helper that encoder-side checkers use as a golden reference.
// Contents:
//   dec_state_e   decoder FSM states {WAIT_KEY, RUN}
//   DW_DEF/MW_DEF default sample and magnitude widths
//   sat_step()    saturating acc +/- mag at DW_DEF width, returns {ovf, result}
// Configuration: none (wrap behaviour, ABS_DIFF_DEC_WRAP_EN, lives in
//                abs_diff_acc_step).
// -----------------------------------------------------------------------------
package abs_diff_pkg;

    localparam int DW_DEF = 8;
    localparam int MW_DEF = 8;

    typedef enum logic [0:0] {
        WAIT_KEY = 1'b0,
        RUN      = 1'b1
    } dec_state_e;

    // The extra top bit of each intermediate catches carry-out on an add and
    // borrow on a subtract.
    function automatic logic [DW_DEF:0] sat_step(
        input logic [DW_DEF-1:0] acc,
        input logic              sign,
        input logic [MW_DEF-1:0] mag
    );
        logic [DW_DEF:0] wide_acc;
        logic [DW_DEF:0] wide_mag;
        logic [DW_DEF:0] wide_res;
        logic [DW_DEF:0] ret;
        wide_acc = {1'b0, acc};
        wide_mag = (DW_DEF+1)'(mag);
        ret      = {(DW_DEF+1){1'b0}};
        if (sign) begin
            wide_res = wide_acc - wide_mag;
            if (wide_res[DW_DEF]) begin
                ret = {1'b1, {DW_DEF{1'b0}}};
            end else begin
                ret = {1'b0, wide_res[DW_DEF-1:0]};
            end
        end else begin
            wide_res = wide_acc + wide_mag;
            if (wide_res[DW_DEF]) begin
                ret = {1'b1, {DW_DEF{1'b1}}};
            end else begin
                ret = {1'b0, wide_res[DW_DEF-1:0]};
            end
        end
        return ret;
    endfunction

endpackage

// File: rtl/abs_diff_acc_step.sv
// -----------------------------------------------------------------------------
// abs_diff_acc_step
// Purpose : Combinational accumulator step: result = acc +/- mag, computed one
//           bit wider than the sample so that overflow and underflow are
//           visible. Saturates by default.
// Configuration: `define ABS_DIFF_DEC_WRAP_EN selects modulo-2^DW arithmetic
//           instead of saturation; ovf_o is raised on wrap in either mode.
// Ports:
//   acc_i    in  DW  current accumulator
//   sign_i   in  1   0 = add, 1 = subtract
//   mag_i    in  MW  magnitude, zero-extended to DW
//   result_o out DW  stepped accumulator value
//   ovf_o    out 1   result left the 0..2^DW-1 range (before saturate/wrap)
// -----------------------------------------------------------------------------
module abs_diff_acc_step #(
    parameter int DW = 8,
    parameter int MW = 8
) (
    input  logic [DW-1:0] acc_i,
    input  logic          sign_i,
    input  logic [MW-1:0] mag_i,
    output logic [DW-1:0] result_o,
    output logic          ovf_o
);

    logic [DW:0] mag_w;
    logic [DW:0] sum_w;
    logic [DW:0] diff_w;

    assign mag_w  = (DW+1)'(mag_i);
    assign sum_w  = {1'b0, acc_i} + mag_w;
    assign diff_w = {1'b0, acc_i} - mag_w;

    // Select add/subtract and clamp or wrap the out-of-range result.
    always_comb begin
        result_o = {DW{1'b0}};
        ovf_o    = 1'b0;
        if (sign_i) begin
            // Bit DW of the difference is the borrow: the result went below 0.
            ovf_o = diff_w[DW];
`ifdef ABS_DIFF_DEC_WRAP_EN
            result_o = diff_w[DW-1:0];
`else
            if (diff_w[DW]) begin
                result_o = {DW{1'b0}};
            end else begin
                result_o = diff_w[DW-1:0];
            end
`endif
        end else begin
            ovf_o = sum_w[DW];
`ifdef ABS_DIFF_DEC_WRAP_EN
            result_o = sum_w[DW-1:0];
`else
            if (sum_w[DW]) begin
                result_o = {DW{1'b1}};
            end else begin
                result_o = sum_w[DW-1:0];
            end
`endif
        end
    end

endmodule

// File: rtl/abs_diff_delta_decoder.sv
// -----------------------------------------------------------------------------
// abs_diff_delta_decoder
// Purpose : Rebuilds a sample stream from (key | sign, magnitude) delta tokens.
//           A frame starts with a keyframe carrying an absolute value; each
//           following delta adds or subtracts a magnitude. The FRAME_LEN-th
//           sample of a frame is flagged with out_last, after which a new
//           keyframe is required.
// Configuration: `define ABS_DIFF_DEC_WRAP_EN for modulo arithmetic in the
//           accumulator step (default saturates).
// Ports:
//   clk        in  1   clock, rising edge
//   rst        in  1   asynchronous active-high reset
//   in_valid   in  1   token valid
//   in_ready   out 1   token accepted on in_valid & in_ready
//   in_key     in  1   keyframe token, in_mag is the absolute value
//   in_sign    in  1   delta direction: 0 add, 1 subtract
//   in_mag     in  MW  magnitude / keyframe value
//   out_valid  out 1   sample valid
//   out_ready  in  1   sample consumed on out_valid & out_ready
//   out_data   out DW  reconstructed sample
//   out_last   out 1   last sample of the frame
//   err_ovf    out 1   sticky, accumulator saturated or wrapped
//   err_nokey  out 1   sticky, delta token seen while waiting for a key
// -----------------------------------------------------------------------------
module abs_diff_delta_decoder
    import abs_diff_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int MW        = MW_DEF,
    parameter int FRAME_LEN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_key,
    input  logic          in_sign,
    input  logic [MW-1:0] in_mag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          err_ovf,
    output logic          err_nokey
);

    localparam int            CW       = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN);

    dec_state_e    state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_nokey_q, err_nokey_d;

    logic          in_ready_s;
    logic          accept_s;
    logic [DW-1:0] mag_ext_s;
    logic [DW-1:0] step_res_s;
    logic          step_ovf_s;
    logic [CW-1:0] cnt_next_s;

    // The single output register can take a new sample whenever it is empty
    // or being drained in this very cycle, which gives 1 token/cycle.
    assign in_ready_s = ~out_valid_q | out_ready;
    assign accept_s   = in_valid & in_ready_s;
    assign mag_ext_s  = DW'(in_mag);

    abs_diff_acc_step #(
        .DW (DW),
        .MW (MW)
    ) u_step (
        .acc_i    (acc_q),
        .sign_i   (in_sign),
        .mag_i    (in_mag),
        .result_o (step_res_s),
        .ovf_o    (step_ovf_s)
    );

    // Next-state logic: FSM, frame counter, accumulator, output stage, flags.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        err_ovf_d   = err_ovf_q;
        err_nokey_d = err_nokey_q;
        cnt_next_s  = cnt_q + CNT_ONE;

        // Drop the sample once consumed; a token accepted below re-fills it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (accept_s) begin
            case (state_q)
                WAIT_KEY: begin
                    if (in_key) begin
                        acc_d       = mag_ext_s;
                        out_valid_d = 1'b1;
                        out_data_d  = mag_ext_s;
                        out_last_d  = 1'b0;
                        cnt_d       = CNT_ONE;
                        state_d     = RUN;
                    end else begin
                        // Delta without a reference value: discard it.
                        err_nokey_d = 1'b1;
                    end
                end
                RUN: begin
                    if (in_key) begin
                        // Key mid-frame restarts the frame count.
                        acc_d      = mag_ext_s;
                        out_data_d = mag_ext_s;
                        cnt_next_s = CNT_ONE;
                    end else begin
                        acc_d      = step_res_s;
                        out_data_d = step_res_s;
                        if (step_ovf_s) begin
                            err_ovf_d = 1'b1;
                        end else begin
                            err_ovf_d = err_ovf_q;
                        end
                    end
                    out_valid_d = 1'b1;
                    // Frame end is decided at acceptance, not at the output
                    // handshake, so the next token already sees WAIT_KEY.
                    if (cnt_next_s == CNT_LAST) begin
                        out_last_d = 1'b1;
                        cnt_d      = CNT_ZERO;
                        state_d    = WAIT_KEY;
                    end else begin
                        out_last_d = 1'b0;
                        cnt_d      = cnt_next_s;
                        state_d    = RUN;
                    end
                end
                default: begin
                    state_d = WAIT_KEY;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_KEY;
            acc_q       <= {DW{1'b0}};
            cnt_q       <= CNT_ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
            out_last_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_nokey_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_ovf_q   <= err_ovf_d;
            err_nokey_q <= err_nokey_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign err_ovf   = err_ovf_q;
    assign err_nokey = err_nokey_q;

endmodule

// File: tb/tb_abs_diff_delta_decoder.sv
// -----------------------------------------------------------------------------
// tb_abs_diff_delta_decoder
// Self-checking bench: tokens are pushed through a frame-level reference
// model on acceptance; expected samples are queued and a negedge monitor
// compares every output handshake against the queue. Honours
// ABS_DIFF_DEC_WRAP_EN in the reference model.
// -----------------------------------------------------------------------------
module tb_abs_diff_delta_decoder;

    localparam int DW   = 8;
    localparam int MW   = 8;
    localparam int FL   = 4;
    localparam int MAXV = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_key = 1'b0;
    logic          in_sign = 1'b0;
    logic [MW-1:0] in_mag = 8'd0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          err_ovf;
    logic          err_nokey;

    logic man_r = 1'b1;
    logic rnd_r = 1'b1;
    logic rnd_bp = 1'b0;
    assign out_ready = rnd_bp ? rnd_r : man_r;

    always #5 clk = ~clk;

    abs_diff_delta_decoder #(.DW(DW), .MW(MW), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_sign   (in_sign),
        .in_mag    (in_mag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err_ovf   (err_ovf),
        .err_nokey (err_nokey)
    );

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hs_cnt = 0;

    // Reference model: frame-level view of the stream.
    int m_acc = 0;
    int m_cnt = 0;
    bit m_run = 1'b0;
    bit m_ovf = 1'b0;
    bit m_nokey = 1'b0;

    always @(posedge clk) begin
        #1;
        rnd_r = 1'($urandom % 2);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_exp(input int d, input bit l);
        exp_t e;
        e.data = d;
        e.last = l;
        sbq.push_back(e);
    endfunction

    function automatic void model_reset();
        m_acc = 0;
        m_cnt = 0;
        m_run = 1'b0;
        m_ovf = 1'b0;
        m_nokey = 1'b0;
    endfunction

    function automatic void model_accept(input bit key, input bit sign, input int mag);
        int r;
        if (key) begin
            m_acc = mag;
            m_cnt = 1;
            m_run = 1'b1;
            push_exp(mag, 1'b0);
        end else if (!m_run) begin
            m_nokey = 1'b1;
        end else begin
            r = sign ? (m_acc - mag) : (m_acc + mag);
            if (r < 0 || r > MAXV) begin
                m_ovf = 1'b1;
`ifdef ABS_DIFF_DEC_WRAP_EN
                r = (r + MAXV + 1) % (MAXV + 1);
`else
                r = (r < 0) ? 0 : MAXV;
`endif
            end
            m_acc = r;
            m_cnt++;
            if (m_cnt == FL) begin
                push_exp(r, 1'b1);
                m_run = 1'b0;
                m_cnt = 0;
            end else begin
                push_exp(r, 1'b0);
            end
        end
    endfunction

    // Monitor: every output handshake must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            hs_cnt++;
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got data %0d, expected no output", out_data);
            end else begin
                e = sbq.pop_front();
                check("out_data", int'(out_data), e.data);
                check("out_last", int'(out_last), int'(e.last));
            end
        end
    end

    task automatic drive_tok(input bit key, input bit sign, input int mag);
        in_valid = 1'b1;
        in_key   = key;
        in_sign  = sign;
        in_mag   = mag[MW-1:0];
    endtask

    // Waits (bounded) until the driven token is accepted; returns at posedge+1.
    task automatic wait_acc(output int waited);
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(in_key, in_sign, int'(in_mag));
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            waited++;
            if (waited > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: got no in_ready, expected acceptance within 200 cycles");
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic put(input bit key, input bit sign, input int mag, output int waited);
        drive_tok(key, sign, mag);
        wait_acc(waited);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int wsum;
        int hs0;
        int held;

        // Reset values while rst is held.
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_err_ovf", int'(err_ovf), 0);
        check("rst_err_nokey", int'(err_nokey), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Basic reconstruction and 1-cycle latency.
        put(1'b1, 1'b0, 100, w);
        check("latency_valid", int'(out_valid), 1);
        put(1'b0, 1'b0, 5, w);
        check("latency_valid2", int'(out_valid), 1);
        put(1'b0, 1'b1, 20, w);
        idle(2);
        check("no_ovf_yet", int'(err_ovf), 0);

        // Overflow on add, underflow on subtract.
        put(1'b1, 1'b0, 250, w);
        put(1'b0, 1'b0, 10, w);
        check("err_ovf_add", int'(err_ovf), 1);
        put(1'b1, 1'b0, 3, w);
        put(1'b0, 1'b1, 9, w);
        idle(2);

        // Full frame, then a delta with no key.
        put(1'b1, 1'b0, 10, w);
        put(1'b0, 1'b0, 1, w);
        put(1'b0, 1'b0, 1, w);
        put(1'b0, 1'b0, 1, w);
        idle(3);
        hs0 = hs_cnt;
        check("nokey_before", int'(err_nokey), 0);
        put(1'b0, 1'b0, 1, w);
        check("err_nokey_set", int'(err_nokey), 1);
        idle(3);
        check("nokey_no_output", hs_cnt, hs0);
        check("nokey_valid_low", int'(out_valid), 0);

        // Backpressure: hold out_ready low for 5 cycles after the first output.
        man_r = 1'b0;
        put(1'b1, 1'b0, 42, w);
        drive_tok(1'b0, 1'b0, 3);
        held = 1;
        repeat (5) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_data !== 8'd42 || out_valid !== 1'b1) held = 0;
        end
        check("hold_stable", held, 1);
        @(posedge clk);
        #1;
        man_r = 1'b1;
        wait_acc(w);
        idle(3);

        // 8 back-to-back tokens with continuous out_ready.
        hs0 = hs_cnt;
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            put((i % FL) == 0, 1'($urandom % 2), int'($urandom % 16), w);
            wsum += w;
        end
        check("stream_stall_cycles", wsum, 0);
        idle(2);
        check("stream_outputs", hs_cnt - hs0, 8);

        // Asynchronous reset mid-stream with a pending output.
        put(1'b1, 1'b0, 50, w);
        put(1'b0, 1'b0, 1, w);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_err_ovf", int'(err_ovf), 0);
        check("midrst_err_nokey", int'(err_nokey), 0);
        check("midrst_data", int'(out_data), 0);
        sbq.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        put(1'b1, 1'b0, 7, w);
        idle(2);

        // Randomised phase with random backpressure.
        rnd_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            put(($urandom % 5) == 0, 1'($urandom % 2), int'($urandom % 256), w);
            if (($urandom % 4) == 0) idle(int'($urandom % 3));
        end
        rnd_bp = 1'b0;
        man_r = 1'b1;
        idle(5);
        check("final_queue_empty", sbq.size(), 0);
        check("final_err_ovf", int'(err_ovf), int'(m_ovf));
        check("final_err_nokey", int'(err_nokey), int'(m_nokey));
        check("final_valid_low", int'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
